// File: rtl/sum_acc_pkg.sv
// Shared types and defaults for the sum_accumulator block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: FSM state enum, default widths/batch size, count-width helper.
package sum_acc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,  // no samples in the current batch
    ACCUM = 2'd1,  // batch partially filled
    HOLD  = 2'd2   // completed batch presented on the output
  } state_t;

  localparam int DEF_IN_W    = 4;
  localparam int DEF_ACC_W   = 8;
  localparam int DEF_CNT_MAX = 8;

  // Width needed to hold a sample count in the range 0..cnt_max.
  function automatic int cnt_w(input int cnt_max);
    return $clog2(cnt_max + 1);
  endfunction

endpackage

// File: rtl/sum_accumulator_if.sv
// Handshake bundle between the adder-side producer, the accumulator and the result consumer.
// Latency: n/a (wires only).
// Backpressure: in_ready throttles the sample channel, out_ready holds the result channel.
//
// Signals:
//   in_valid/in_ready/in_sum            sample channel (producer -> accumulator)
//   out_valid/out_ready/out_acc/
//   out_count/out_ovf                   result channel (accumulator -> consumer)
// Modports: master = environment side (producer + consumer), slave = accumulator.
interface sum_accumulator_if
  import sum_acc_pkg::*;
#(
  parameter int IN_W    = DEF_IN_W,
  parameter int ACC_W   = DEF_ACC_W,
  parameter int CNT_MAX = DEF_CNT_MAX
) ();

  localparam int CNT_W = cnt_w(CNT_MAX);

  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_sum;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_acc;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;

  modport master (
    output in_valid, in_sum, out_ready,
    input  in_ready, out_valid, out_acc, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_sum, out_ready,
    output in_ready, out_valid, out_acc, out_count, out_ovf
  );

endinterface

// File: rtl/sum_accumulator_acc_add_sat.sv
// Combinational accumulator adder: acc + zero-extended sample, with carry-out.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
//
// Ports: i_acc (ACC_W), i_sum (IN_W) in; o_next_acc (ACC_W), o_carry out.
// Build option SUM_ACCUMULATOR_SATURATE_EN: on carry-out the result clamps to all-ones
// instead of wrapping.
module acc_add_sat #(
  parameter int IN_W  = 4,
  parameter int ACC_W = 8
) (
  input  logic [ACC_W-1:0] i_acc,
  input  logic [IN_W-1:0]  i_sum,
  output logic [ACC_W-1:0] o_next_acc,
  output logic             o_carry
);

  localparam int SUM_W = ACC_W + 1;

  logic [ACC_W:0] w_wide;

  // One extra bit so the carry-out is visible without a separate compare.
  assign w_wide  = {1'b0, i_acc} + SUM_W'(i_sum);
  assign o_carry = w_wide[ACC_W];

`ifdef SUM_ACCUMULATOR_SATURATE_EN
  // Once clamped, acc stays at all-ones: any further non-zero add carries again.
  assign o_next_acc = o_carry ? {ACC_W{1'b1}} : w_wide[ACC_W-1:0];
`else
  assign o_next_acc = w_wide[ACC_W-1:0];
`endif

endmodule

// File: rtl/sum_accumulator.sv
// Batch accumulator for adder sums: totals CNT_MAX samples, then presents total/count/overflow.
// Latency: out_valid rises one cycle after the edge that accepts the last sample of a batch.
// Backpressure: result held while out_ready=0; in_ready=0 in HOLD and during clear (no bypass).
//
// Ports: clk, rst_n (sync, active-low), clear (sync batch abort), bus (sum_accumulator_if.slave).
// Build option SUM_ACCUMULATOR_SATURATE_EN: saturate acc instead of wrapping (see acc_add_sat).
module sum_accumulator
  import sum_acc_pkg::*;
#(
  parameter int IN_W    = DEF_IN_W,
  parameter int ACC_W   = DEF_ACC_W,
  parameter int CNT_MAX = DEF_CNT_MAX
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  sum_accumulator_if.slave bus
);

  localparam int CNT_W = cnt_w(CNT_MAX);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX);

  state_t           r_state, w_state_nxt;
  logic [ACC_W-1:0] r_acc, w_acc_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_ovf, w_ovf_nxt;
  logic             r_out_vld;

  logic             w_in_rdy;
  logic             w_accept;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [ACC_W-1:0] w_add_acc;
  logic             w_add_carry;

  acc_add_sat #(
    .IN_W  (IN_W),
    .ACC_W (ACC_W)
  ) u_add (
    .i_acc      (r_acc),
    .i_sum      (bus.in_sum),
    .o_next_acc (w_add_acc),
    .o_carry    (w_add_carry)
  );

  assign w_in_rdy  = (r_state != HOLD) && !clear;
  assign w_accept  = bus.in_valid && w_in_rdy;
  assign w_cnt_inc = r_cnt + CNT_W'(1);

  // Next-state / datapath
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_ovf_nxt   = r_ovf;

    if (clear) begin
      w_state_nxt = IDLE;
      w_acc_nxt   = '0;
      w_cnt_nxt   = '0;
      w_ovf_nxt   = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            // First sample loads directly; nothing to add to.
            w_acc_nxt   = ACC_W'(bus.in_sum);
            w_cnt_nxt   = CNT_W'(1);
            w_ovf_nxt   = 1'b0;
            w_state_nxt = (CNT_MAX == 1) ? HOLD : ACCUM;
          end
        end
        ACCUM: begin
          if (w_accept) begin
            w_acc_nxt = w_add_acc;
            w_cnt_nxt = w_cnt_inc;
            w_ovf_nxt = r_ovf | w_add_carry;
            if (w_cnt_inc == CNT_LAST) begin
              w_state_nxt = HOLD;
            end
          end
        end
        HOLD: begin
          // out_valid is high throughout HOLD, so out_ready alone completes the handshake.
          if (bus.out_ready) begin
            w_state_nxt = IDLE;
            w_acc_nxt   = '0;
            w_cnt_nxt   = '0;
            w_ovf_nxt   = 1'b0;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_acc_nxt   = '0;
          w_cnt_nxt   = '0;
          w_ovf_nxt   = 1'b0;
        end
      endcase
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_ovf     <= 1'b0;
      r_out_vld <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_acc     <= w_acc_nxt;
      r_cnt     <= w_cnt_nxt;
      r_ovf     <= w_ovf_nxt;
      // Registered copy of (state==HOLD) so out_valid comes straight from a flop.
      r_out_vld <= (w_state_nxt == HOLD);
    end
  end

  assign bus.in_ready  = w_in_rdy;
  assign bus.out_valid = r_out_vld;
  assign bus.out_acc   = r_acc;
  assign bus.out_count = r_cnt;
  assign bus.out_ovf   = r_ovf;

endmodule

// File: doc/sum_accumulator.md
Name: sum_accumulator

Overview:
- Downstream consumer of the 3-bit ripple adder (`circuito`): takes its 4-bit sum {s3,s2,s1,s0} one sample per handshake.
- Accumulates a batch of CNT_MAX sums into a wider register, then presents the total with a sample count and overflow flag.
- The result is held on a valid/ready output until the consumer accepts it; the block then re-arms for the next batch.
- Used to exercise the adder over multi-cycle sequences and to total its results.

Parameters:
- IN_W, 4, width of incoming sum (3-bit operands + carry-out).
- ACC_W, 8, accumulator width; must be >= IN_W.
- CNT_MAX, 8, samples per batch; must be >= 1.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- clear  input  1  synchronous batch abort; discards partial or held result.
- in_valid  input  1  in_sum is valid this cycle.
- in_ready  output  1  block can accept a sample this cycle.
- in_sum  input  IN_W  adder sum {s3,s2,s1,s0}; zero-extended to ACC_W.
- out_valid  output  1  out_acc, out_count and out_ovf hold a completed batch.
- out_ready  input  1  consumer accepts the result.
- out_acc  output  ACC_W  batch total.
- out_count  output  $clog2(CNT_MAX+1)  samples accepted in the current batch.
- out_ovf  output  1  sticky: the accumulator exceeded 2^ACC_W-1 during the batch.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low.
- Reset (rst_n=0 at a clock edge): state=IDLE, acc=0, count=0, ovf=0, out_valid=0. This holds mid-batch or mid-HOLD; any pending result is lost.
- FSM states: IDLE (count=0), ACCUM (0<count<CNT_MAX), HOLD (result presented).
- in_ready = (state!=HOLD) && !clear, combinational.
- accept = in_valid && in_ready.
- IDLE: on accept, acc=in_sum, count=1, ovf=0.
  - If CNT_MAX=1 go to HOLD; otherwise go to ACCUM.
  - With no accept, remain in IDLE.
- ACCUM: on accept, add in_sum to acc and increment count.
  - Compute the sum at ACC_W+1 bits; carry-out sets ovf (sticky).
  - acc takes the low ACC_W bits (wrap-around).
  - If the new count equals CNT_MAX, go to HOLD.
- HOLD: out_valid=1; outputs are stable while out_ready=0.
  - On out_valid && out_ready: acc=0, count=0, ovf=0, go to IDLE.
  - in_ready stays 0 in that cycle (no bypass); the next batch starts the following cycle.
- out_valid = (state==HOLD), registered.
- Latency: out_valid rises one cycle after the clock edge that accepts sample CNT_MAX.
- Throughput: one sample per cycle. Minimum batch period is CNT_MAX+1 cycles when out_ready is held at 1.
- out_acc, out_count and out_ovf always reflect internal registers, including partial values in IDLE/ACCUM. They are qualified only by out_valid.
- clear (when rst_n=1): highest priority after reset; from any state, acc=0, count=0, ovf=0, state=IDLE.
  - clear with in_valid=1: the sample is not accepted (in_ready=0).
  - clear with out_ready=1 in HOLD: the result is dropped. out_valid was high, so the consumer may treat this as a completed handshake; the block discards the result regardless.
- in_sum values above 2^IN_W-1 cannot occur. No checking.

Optional Feature:
- Macro: SUM_ACCUMULATOR_SATURATE_EN.
- Defined: on carry-out, acc saturates to 2^ACC_W-1 and stays there for the rest of the batch. ovf is still set.
- Undefined: wrap-around modulo 2^ACC_W as described above.
- Handshake, latency and count behaviour are identical in both builds.

Decomposition:
- Shared package sum_acc_pkg:
  - state enum {IDLE, ACCUM, HOLD};
  - localparams for default IN_W, ACC_W and CNT_MAX;
  - function returning the count width $clog2(CNT_MAX+1).
- One natural sub-module: acc_add_sat, a combinational ACC_W-bit adder taking acc and the zero-extended in_sum and returning next_acc and carry. Saturation is handled inside it under the macro.
- FSM and registers stay in sum_accumulator.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=1 -> out_valid=0, in_ready=1 after release, out_acc=0, out_count=0, out_ovf=0.
- Basic batch, CNT_MAX=4, out_ready=1: in_sum 3,5,7,15 on consecutive cycles -> out_valid one cycle after the 4th accept, out_acc=30, out_count=4, out_ovf=0. in_ready=0 for 1 cycle, then 1.
- Backpressure, CNT_MAX=4: same stimulus with out_ready=0 for 5 cycles -> out_acc=30 stable, in_ready=0 throughout, extra in_valid pulses ignored. Release out_ready -> IDLE next cycle.
- Overflow, CNT_MAX=20: twenty samples of 15 -> wrap build: out_acc=44, out_ovf=1. SATURATE_EN build: out_acc=255, out_ovf=1.
- Clear, CNT_MAX=4: clear asserted together with the 3rd in_valid -> sample not accepted, out_count=0. The next 4 samples of 1 give out_acc=4.
- Mid-HOLD reset: rst_n=0 while out_valid=1 -> out_valid=0 and all outputs 0 on the next edge, no result delivered.
